// File: rtl/v_wb_arbiter.sv
// Vector writeback arbiter: round-robin between ALU register-group writebacks
// and load-unit element writebacks, registered regfile write stage, and a
// pending-write scoreboard with combinational hazard query.
module v_wb_arbiter #(
  parameter int V_REGS = 32,
  parameter int DW     = 128
) (
  input  logic              clk,
  input  logic              nrst,
  // ALU writeback
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_vd,
  input  logic [2:0]        alu_lmul,
  input  logic [DW-1:0]     alu_data_a,
  input  logic [DW-1:0]     alu_data_b,
  input  logic [DW-1:0]     alu_data_c,
  input  logic [DW-1:0]     alu_data_d,
  // Load-unit element writeback
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [4:0]        lsu_vd,
  input  logic [4:0]        lsu_el_idx,
  input  logic [DW-1:0]     lsu_data,
  input  logic              lsu_last,
  // Issue marks destination group pending
  input  logic              iss_valid,
  input  logic [4:0]        iss_vd,
  input  logic [2:0]        iss_lmul,
  // Hazard query
  input  logic [4:0]        q_vs1,
  input  logic [4:0]        q_vs2,
  input  logic [2:0]        q_lmul,
  output logic              hazard,
  output logic [V_REGS-1:0] pending,
  // Regfile register port
  output logic              rf_reg_wr_en,
  output logic [4:0]        rf_reg_wr_addr,
  output logic [2:0]        rf_lmul,
  output logic [DW-1:0]     rf_reg_wr_data1,
  output logic [DW-1:0]     rf_reg_wr_data2,
  output logic [DW-1:0]     rf_reg_wr_data3,
  output logic [DW-1:0]     rf_reg_wr_data4,
  // Regfile element port
  output logic              rf_el_wr_en,
  output logic [4:0]        rf_el_reg_wr_addr,
  output logic [4:0]        rf_el_wr_addr,
  output logic [DW-1:0]     rf_el_wr_data
);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

  grant_e            last_grant;
  logic              out_last;
  logic              alu_acc;
  logic              lsu_acc;
  logic [V_REGS-1:0] clr_mask;
  logic [V_REGS-1:0] set_mask;

  // Registers vd .. vd+n-1 for group size n; bits shifted past the top drop out.
  function automatic logic [V_REGS-1:0] group_mask(input logic [4:0] vd,
                                                    input logic [2:0] lmul);
    logic [V_REGS-1:0] m;
    int unsigned       n;
    m = '0;
    case (lmul)
      3'd1:    n = 2;
      3'd2:    n = 4;
      default: n = 1;
    endcase
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < n) m = m | (V_REGS'(1) << (32'(vd) + i));
    end
    return m;
  endfunction

  // Round-robin grant; nothing is granted while reset is asserted.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (nrst) begin
      if (alu_valid && lsu_valid) begin
        if (last_grant == GRANT_LSU) alu_ready = 1'b1;
        else                         lsu_ready = 1'b1;
      end else begin
        alu_ready = alu_valid;
        lsu_ready = lsu_valid;
      end
    end
  end

  assign alu_acc = alu_valid & alu_ready;
  assign lsu_acc = lsu_valid & lsu_ready;

  // Remember the most recent winner for the next contest.
  always_ff @(posedge clk) begin
    if (!nrst)        last_grant <= GRANT_LSU;
    else if (alu_acc) last_grant <= GRANT_ALU;
    else if (lsu_acc) last_grant <= GRANT_LSU;
  end

  // Registered regfile write stage; payload fields hold when idle.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rf_reg_wr_en      <= 1'b0;
      rf_reg_wr_addr    <= '0;
      rf_lmul           <= '0;
      rf_reg_wr_data1   <= '0;
      rf_reg_wr_data2   <= '0;
      rf_reg_wr_data3   <= '0;
      rf_reg_wr_data4   <= '0;
      rf_el_wr_en       <= 1'b0;
      rf_el_reg_wr_addr <= '0;
      rf_el_wr_addr     <= '0;
      rf_el_wr_data     <= '0;
      out_last          <= 1'b0;
    end else begin
      rf_reg_wr_en <= alu_acc;
      rf_el_wr_en  <= lsu_acc;
      if (alu_acc) begin
        rf_reg_wr_addr  <= alu_vd;
        rf_lmul         <= alu_lmul;
        rf_reg_wr_data1 <= alu_data_a;
        rf_reg_wr_data2 <= alu_data_b;
        rf_reg_wr_data3 <= alu_data_c;
        rf_reg_wr_data4 <= alu_data_d;
      end
      if (lsu_acc) begin
        rf_el_reg_wr_addr <= lsu_vd;
        rf_el_wr_addr     <= lsu_el_idx;
        rf_el_wr_data     <= lsu_data;
        out_last          <= lsu_last;
      end
    end
  end

  // Scoreboard update masks: clears come from the write currently in the output stage.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (rf_reg_wr_en)            clr_mask = clr_mask | group_mask(rf_reg_wr_addr, rf_lmul);
    if (rf_el_wr_en && out_last) clr_mask = clr_mask | (V_REGS'(1) << rf_el_reg_wr_addr);
    if (iss_valid)               set_mask = group_mask(iss_vd, iss_lmul);
  end

  // Pending scoreboard; a same-cycle set overrides a clear.
  always_ff @(posedge clk) begin
    if (!nrst) pending <= '0;
    else       pending <= (pending & ~clr_mask) | set_mask;
  end

  // Read-after-write hazard against either source group.
  always_comb begin
    hazard = |(pending & (group_mask(q_vs1, q_lmul) | group_mask(q_vs2, q_lmul)));
  end

endmodule

// File: tb/tb_v_wb_arbiter.sv
// Self-checking bench for v_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a per-register behavioural model.
module tb_v_wb_arbiter;
  localparam int V_REGS = 32;
  localparam int DW     = 128;

  logic clk = 1'b0;
  logic nrst;
  logic alu_valid, alu_ready;
  logic [4:0] alu_vd;
  logic [2:0] alu_lmul;
  logic [DW-1:0] alu_data_a, alu_data_b, alu_data_c, alu_data_d;
  logic lsu_valid, lsu_ready;
  logic [4:0] lsu_vd, lsu_el_idx;
  logic [DW-1:0] lsu_data;
  logic lsu_last;
  logic iss_valid;
  logic [4:0] iss_vd;
  logic [2:0] iss_lmul;
  logic [4:0] q_vs1, q_vs2;
  logic [2:0] q_lmul;
  logic hazard;
  logic [V_REGS-1:0] pending;
  logic rf_reg_wr_en;
  logic [4:0] rf_reg_wr_addr;
  logic [2:0] rf_lmul;
  logic [DW-1:0] rf_reg_wr_data1, rf_reg_wr_data2, rf_reg_wr_data3, rf_reg_wr_data4;
  logic rf_el_wr_en;
  logic [4:0] rf_el_reg_wr_addr, rf_el_wr_addr;
  logic [DW-1:0] rf_el_wr_data;

  v_wb_arbiter #(.V_REGS(V_REGS), .DW(DW)) dut (
    .clk(clk), .nrst(nrst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_vd(alu_vd), .alu_lmul(alu_lmul),
    .alu_data_a(alu_data_a), .alu_data_b(alu_data_b), .alu_data_c(alu_data_c), .alu_data_d(alu_data_d),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_vd(lsu_vd), .lsu_el_idx(lsu_el_idx),
    .lsu_data(lsu_data), .lsu_last(lsu_last),
    .iss_valid(iss_valid), .iss_vd(iss_vd), .iss_lmul(iss_lmul),
    .q_vs1(q_vs1), .q_vs2(q_vs2), .q_lmul(q_lmul), .hazard(hazard), .pending(pending),
    .rf_reg_wr_en(rf_reg_wr_en), .rf_reg_wr_addr(rf_reg_wr_addr), .rf_lmul(rf_lmul),
    .rf_reg_wr_data1(rf_reg_wr_data1), .rf_reg_wr_data2(rf_reg_wr_data2),
    .rf_reg_wr_data3(rf_reg_wr_data3), .rf_reg_wr_data4(rf_reg_wr_data4),
    .rf_el_wr_en(rf_el_wr_en), .rf_el_reg_wr_addr(rf_el_reg_wr_addr),
    .rf_el_wr_addr(rf_el_wr_addr), .rf_el_wr_data(rf_el_wr_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit            m_last_alu;
  bit            m_pend[V_REGS];
  bit            m_reg_en, m_el_en, m_last;
  logic [4:0]    m_reg_addr, m_el_reg, m_el_idx;
  logic [2:0]    m_lmul;
  logic [DW-1:0] m_rd[4];
  logic [DW-1:0] m_el_data;
  bit            ga, gl;
  int            reg_pulses, el_pulses;

  function automatic int grp_n(input logic [2:0] l);
    if (l == 3'd1) return 2;
    if (l == 3'd2) return 4;
    return 1;
  endfunction

  function automatic bit in_grp(input int r, input logic [4:0] vd, input logic [2:0] l);
    int base;
    base = int'(vd);
    return (r >= base) && (r < base + grp_n(l));
  endfunction

  function automatic logic [V_REGS-1:0] pend_word();
    logic [V_REGS-1:0] w;
    for (int r = 0; r < V_REGS; r++) w[r] = m_pend[r];
    return w;
  endfunction

  task automatic model_reset();
    m_last_alu = 1'b0;
    for (int r = 0; r < V_REGS; r++) m_pend[r] = 1'b0;
    m_reg_en = 0; m_el_en = 0; m_last = 0;
    m_reg_addr = '0; m_el_reg = '0; m_el_idx = '0; m_lmul = '0;
    for (int k = 0; k < 4; k++) m_rd[k] = '0;
    m_el_data = '0;
  endtask

  // Called at posedge+1 with inputs already driven; checks mid-cycle, then advances.
  task automatic step(output bit o_ga, output bit o_gl);
    bit a, l, hz;
    #3;
    a = 0; l = 0;
    if (nrst) begin
      if (alu_valid && lsu_valid) begin
        a = !m_last_alu;
        l = m_last_alu;
      end else begin
        a = alu_valid;
        l = lsu_valid;
      end
    end
    hz = 0;
    for (int r = 0; r < V_REGS; r++)
      if (m_pend[r] && (in_grp(r, q_vs1, q_lmul) || in_grp(r, q_vs2, q_lmul))) hz = 1;
    check("alu_ready", alu_ready, a);
    check("lsu_ready", lsu_ready, l);
    check("hazard", hazard, hz);
    check("pending", pending, pend_word());
    check("reg_en", rf_reg_wr_en, m_reg_en);
    check("reg_addr", rf_reg_wr_addr, m_reg_addr);
    check("rf_lmul", rf_lmul, m_lmul);
    check("reg_data1", rf_reg_wr_data1, m_rd[0]);
    check("reg_data2", rf_reg_wr_data2, m_rd[1]);
    check("reg_data3", rf_reg_wr_data3, m_rd[2]);
    check("reg_data4", rf_reg_wr_data4, m_rd[3]);
    check("el_en", rf_el_wr_en, m_el_en);
    check("el_reg", rf_el_reg_wr_addr, m_el_reg);
    check("el_idx", rf_el_wr_addr, m_el_idx);
    check("el_data", rf_el_wr_data, m_el_data);
    check("en_exclusive", rf_reg_wr_en & rf_el_wr_en, 1'b0);
    @(posedge clk);
    if (!nrst) begin
      model_reset();
    end else begin
      for (int r = 0; r < V_REGS; r++) begin
        if (iss_valid && in_grp(r, iss_vd, iss_lmul))
          m_pend[r] = 1'b1;
        else if ((m_reg_en && in_grp(r, m_reg_addr, m_lmul)) ||
                 (m_el_en && m_last && r == int'(m_el_reg)))
          m_pend[r] = 1'b0;
      end
      m_reg_en = a;
      m_el_en  = l;
      if (a) begin
        m_reg_addr = alu_vd; m_lmul = alu_lmul;
        m_rd[0] = alu_data_a; m_rd[1] = alu_data_b; m_rd[2] = alu_data_c; m_rd[3] = alu_data_d;
        m_last_alu = 1'b1;
      end
      if (l) begin
        m_el_reg = lsu_vd; m_el_idx = lsu_el_idx; m_el_data = lsu_data; m_last = lsu_last;
        m_last_alu = 1'b0;
      end
    end
    #1;
    o_ga = a;
    o_gl = l;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic new_alu(input logic [4:0] vd, input logic [2:0] lm);
    alu_valid = 1; alu_vd = vd; alu_lmul = lm;
    alu_data_a = rnd_data(); alu_data_b = rnd_data(); alu_data_c = rnd_data(); alu_data_d = rnd_data();
  endtask

  task automatic new_lsu(input logic [4:0] vd, input logic [4:0] idx, input logic last);
    lsu_valid = 1; lsu_vd = vd; lsu_el_idx = idx; lsu_last = last; lsu_data = rnd_data();
  endtask

  initial begin
    nrst = 0; iss_valid = 0; iss_vd = '0; iss_lmul = '0;
    q_vs1 = '0; q_vs2 = '0; q_lmul = '0;
    new_alu(5'd1, 3'd0);
    new_lsu(5'd2, 5'd0, 1'b0);
    model_reset();
    @(posedge clk); #1;

    // Reset with both requesters active
    repeat (2) step(ga, gl);
    check("rst_pending", pending, '0);
    check("rst_reg_en", rf_reg_wr_en, 1'b0);

    // Contention after reset: ALU first, then alternation
    nrst = 1;
    reg_pulses = 0; el_pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step(ga, gl);
      check("cont_reg_en", rf_reg_wr_en, (k % 2 == 0) ? 1'b1 : 1'b0);
      check("cont_el_en", rf_el_wr_en, (k % 2 == 1) ? 1'b1 : 1'b0);
      reg_pulses += int'(rf_reg_wr_en);
      el_pulses  += int'(rf_el_wr_en);
      if (ga) new_alu(5'($urandom), 3'd0);
      if (gl) new_lsu(5'($urandom), 5'($urandom), 1'b0);
    end
    check("cont_reg_pulses", 32'(reg_pulses), 32'd2);
    check("cont_el_pulses", 32'(el_pulses), 32'd2);
    alu_valid = 0; lsu_valid = 0;
    step(ga, gl);

    // ALU LMUL=4 group write and hazard release
    iss_valid = 1; iss_vd = 5'd8; iss_lmul = 3'd2;
    step(ga, gl);
    iss_valid = 0;
    check("iss_g4_pending", pending, 32'h00000F00);
    q_vs1 = 5'd10; q_vs2 = 5'd0; q_lmul = 3'd0;
    new_alu(5'd8, 3'd2);
    alu_data_a = 'hA; alu_data_b = 'hB; alu_data_c = 'hC; alu_data_d = 'hD;
    step(ga, gl);
    alu_valid = 0;
    check("g4_reg_en", rf_reg_wr_en, 1'b1);
    check("g4_addr", rf_reg_wr_addr, 5'd8);
    check("g4_lmul", rf_lmul, 3'd2);
    check("g4_data4", rf_reg_wr_data4, 'hD);
    check("g4_hazard_held", hazard, 1'b1);
    step(ga, gl);
    check("g4_pending_clr", pending, '0);
    check("g4_hazard_drop", hazard, 1'b0);

    // LSU element stream into v3
    iss_valid = 1; iss_vd = 5'd3; iss_lmul = 3'd0;
    step(ga, gl);
    iss_valid = 0;
    for (int e = 0; e < 4; e++) begin
      new_lsu(5'd3, 5'(e), (e == 3) ? 1'b1 : 1'b0);
      step(ga, gl);
      check("lsu_el_en", rf_el_wr_en, 1'b1);
      check("lsu_bit3_held", pending[3], 1'b1);
    end
    lsu_valid = 0;
    step(ga, gl);
    check("lsu_bit3_clr", pending[3], 1'b0);

    // Set and clear of v5 in the same cycle
    new_alu(5'd5, 3'd0);
    step(ga, gl);
    alu_valid = 0;
    iss_valid = 1; iss_vd = 5'd5; iss_lmul = 3'd0;
    step(ga, gl);
    iss_valid = 0;
    check("collide_bit5", pending[5], 1'b1);

    // Top-of-file group and reset during an output-stage write
    nrst = 0;
    step(ga, gl);
    nrst = 1;
    iss_valid = 1; iss_vd = 5'd30; iss_lmul = 3'd2;
    step(ga, gl);
    iss_valid = 0;
    check("nowrap_pending", pending, 32'hC0000000);
    new_alu(5'd30, 3'd2);
    step(ga, gl);
    alu_valid = 0;
    check("pre_rst_reg_en", rf_reg_wr_en, 1'b1);
    nrst = 0;
    step(ga, gl);
    check("mid_rst_reg_en", rf_reg_wr_en, 1'b0);
    check("mid_rst_pending", pending, '0);
    nrst = 1;

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      if (!alu_valid && $urandom_range(0, 2) != 0) new_alu(5'($urandom), 3'($urandom));
      if (!lsu_valid && $urandom_range(0, 2) != 0)
        new_lsu(5'($urandom), 5'($urandom), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_vd = 5'($urandom); iss_lmul = 3'($urandom);
      q_vs1 = 5'($urandom); q_vs2 = 5'($urandom); q_lmul = 3'($urandom);
      nrst = ($urandom_range(0, 99) != 0);
      step(ga, gl);
      if (ga) alu_valid = 0;
      if (gl) lsu_valid = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/v_wb_arbiter.md
# v_wb_arbiter

Writeback arbiter and scoreboard for the vector register file. Accepts register-group writebacks from the vector ALU and element writebacks from the vector load unit, grants one per cycle round-robin, and drives the regfile's register and element write ports from a registered output stage. A 32-entry pending-write scoreboard tracks registers with outstanding writes. Issue logic uses it to stall reads of those registers.

## Interface
- V_REGS, 32, number of vector registers (scoreboard width)
- DW, 128, register width in bits
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- alu_valid / alu_ready  in / out  1 / 1  ALU writeback handshake
- alu_vd  in  5  destination base register
- alu_lmul  in  3  group size: 0→1, 1→2, 2→4, other→1
- alu_data_a..d  in  DW each  data for vd, vd+1, vd+2, vd+3
- lsu_valid / lsu_ready  in / out  1 / 1  load-unit element handshake
- lsu_vd, lsu_el_idx  in  5, 5  destination register, element index
- lsu_data  in  DW  lane-aligned element data
- lsu_last  in  1  final element of the load instruction
- iss_valid, iss_vd, iss_lmul  in  1, 5, 3  marks the instruction's destination group pending
- q_vs1, q_vs2, q_lmul  in  5, 5, 3  hazard query
- hazard  out  1  a pending register overlaps the vs1 group, the vs2 group, or both
- pending  out  V_REGS  scoreboard state
- rf_reg_wr_en, rf_reg_wr_addr, rf_lmul, rf_reg_wr_data..4  out  1, 5, 3, DW×4  to regfile register port
- rf_el_wr_en, rf_el_reg_wr_addr, rf_el_wr_addr, rf_el_wr_data  out  1, 5, 5, DW  to regfile element port

## Operation
- Grant selection is combinational:
  - Only alu_valid: alu_ready=1.
  - Only lsu_valid: lsu_ready=1.
  - Both valid: grant the requester that is not last_grant.
  - At most one ready high per cycle.
- last_grant updates to the granted requester on every accepted transfer. It resets to LSU, so the ALU wins the first contest.
- Output stage is registered:
  - Accepted ALU request: next cycle rf_reg_wr_en=1, with addr, lmul and data copied from the request.
  - Accepted LSU request: next cycle rf_el_wr_en=1, with reg addr, element index and data copied. out_last is latched from lsu_last.
  - Without an accept, both enables are 0 the next cycle. Data and address fields hold their last values.
  - rf_reg_wr_en and rf_el_wr_en are never high together.
- Group mask G(vd,lmul) = bits vd .. vd+n-1, where n ∈ {1,2,4}. Bits beyond 31 are dropped; there is no wrap-around.
- Scoreboard clear, at the edge closing a cycle where the output stage is valid:
  - rf_reg_wr_en=1: clear G(rf_reg_wr_addr, rf_lmul).
  - rf_el_wr_en=1 and out_last=1: clear bit rf_el_reg_wr_addr.
- Scoreboard set: iss_valid=1 sets G(iss_vd, iss_lmul) at the same edge. If a bit is both set and cleared in the same cycle, set wins.
- hazard = |(pending & (G(q_vs1,q_lmul) | G(q_vs2,q_lmul))). It is combinational from the registered pending.
- The block does no alignment checking of vd versus lmul.

## Timing
- Reset values: all outputs 0 (enables, addresses, data, rf_lmul, pending, hazard), and readys 0 while valids are 0. last_grant = LSU.
- Reset mid-operation: the output-stage write is dropped (enables 0 after the reset edge) and pending is cleared.
- Readys are combinational and are ignored while nrst=0; no transfer is accepted during reset.
- Latency:
  - Handshake at edge t → regfile write enable high in cycle t..t+1 → regfile commits at edge t+1.
  - The pending bit clears at the same edge t+1, so hazard drops in the cycle when the regfile data is already readable.
- Throughput: one accepted transfer per cycle. Under continuous contention the ALU and LSU alternate.
- Requesters must hold valid and payload stable until ready is seen.

## Test plan
- Reset: nrst=0 for 2 cycles with both valids high → readys 0, enables 0, pending=0. First post-reset contest grants ALU.
- ALU LMUL=4: iss vd=8 lmul=2 → pending=0x00000F00. Then alu_valid vd=8 with data a..d=0xA..0xD.
  - Next cycle: rf_reg_wr_en=1, addr=8, lmul=2.
  - Following cycle: pending=0, and hazard for q_vs1=10 drops.
- Contention: both valid for 4 cycles → grants ALU, LSU, ALU, LSU.
  - rf_reg_wr_en and rf_el_wr_en each pulse twice, never both high in the same cycle.
- LSU stream: iss vd=3 lmul=0, then elements 0..3 with lsu_last on element 3 → bit 3 stays set through elements 0..2 and clears the cycle after element 3's rf_el_wr_en.
- Set/clear collision: ALU writeback to v5 in its output stage while iss_valid vd=5 → pending[5] remains 1.
- Boundary: iss vd=30 lmul=2 → pending=0xC0000000 (no wrap). Reset asserted while rf_reg_wr_en=1 → enable 0 and pending 0 after the edge.
